// File: rtl/i2c_request_arbiter.sv
// Round-robin arbiter sharing one single-byte I2C write engine between
// NUM_REQ requesters, with NACK retry, retry gap and transfer timeout.
module i2c_request_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int RETRY_MAX      = 2,
    parameter int GAP_CYCLES     = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   req_err,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 eng_start,
    output logic [6:0]           eng_addr,
    output logic [7:0]           eng_data,
    input  logic                 eng_done,
    input  logic                 eng_ack_fail,
    output logic                 timeout_flag
);

    localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CMAX = (GAP_CYCLES > TIMEOUT_CYCLES) ?
                          GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int RW   = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
    localparam logic [IW-1:0] PTR_RST   = IW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        LAUNCH,
        WAIT_DONE,
        GAP,
        RESPOND
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [6:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          tflag_q, tflag_d;

    logic [6:0]    addr_slice [NUM_REQ];
    logic [7:0]    data_slice [NUM_REQ];
    logic          pick_vld;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] cand;
    logic [CW-1:0] cnt_inc;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign addr_slice[g] = req_addr[7*g +: 7];
        assign data_slice[g] = req_data[8*g +: 8];
    end

    // First set request after the last owner, wrapping around.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = ptr_q;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(ptr_q) + k) % NUM_REQ);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign cnt_inc = cnt_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= PTR_RST;
            owner_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            retry_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            tflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            retry_q <= retry_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            tflag_q <= tflag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        data_d  = data_q;
        retry_d = retry_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        tflag_d = tflag_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_d = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                addr_d  = addr_slice[owner_q];
                data_d  = data_slice[owner_q];
                retry_d = '0;
                state_d = LAUNCH;
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                cnt_d = cnt_inc;
                // A done on the terminal count still counts as completion.
                if (eng_done && !eng_ack_fail) begin
                    err_d   = 1'b0;
                    state_d = RESPOND;
                end else if (eng_done && retry_q < RETRY_LIM) begin
                    retry_d = retry_q + 1'b1;
                    cnt_d   = '0;
                    state_d = GAP;
                end else if (eng_done) begin
                    err_d   = 1'b1;
                    state_d = RESPOND;
                end else if (cnt_inc == TO_LAST) begin
                    err_d   = 1'b1;
                    tflag_d = 1'b1;
                    state_d = RESPOND;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = LAUNCH;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESPOND: begin
                ptr_d   = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant     = '0;
        req_ack   = '0;
        req_err   = '0;
        busy      = (state_q != IDLE);
        eng_start = (state_q == LAUNCH);
        if (state_q != IDLE) begin
            grant[owner_q] = 1'b1;
        end
        if (state_q == RESPOND) begin
            req_ack[owner_q] = 1'b1;
            req_err[owner_q] = err_q;
        end
    end

    assign eng_addr     = addr_q;
    assign eng_data     = data_q;
    assign timeout_flag = tflag_q;

endmodule
